// File: rtl/count_enable_gen_pkg.sv
// Shared definitions for the push-button count-enable front end:
// default timing parameters and the FSM state encoding. The bench imports
// this package too, so state checks use the same encodings as the RTL.
package count_enable_gen_pkg;

  localparam int unsigned DEB_CYCLES_DEF  = 4;
  localparam int unsigned HOLD_CYCLES_DEF = 8;
  localparam int unsigned PRESCALE_DEF    = 5;
  localparam int unsigned CNT_W_DEF       = 16;

  // state       | meaning
  // ST_IDLE     | button released and stable
  // ST_PRESS_DB | candidate press, waiting for DEB_CYCLES stable highs
  // ST_PRESSED  | press accepted, timing toward hold-to-clear
  // ST_HELD     | long press already reported, waiting for release
  // ST_REL_DB   | candidate release, waiting for DEB_CYCLES stable lows
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRESS_DB = 3'd1,
    ST_PRESSED  = 3'd2,
    ST_HELD     = 3'd3,
    ST_REL_DB   = 3'd4
  } btn_state_e;

endpackage

// File: rtl/count_enable_gen_sync2.sv
// Two-flop synchroniser for the asynchronous push-button input.
module count_enable_gen_sync2 (
  input  logic clock,
  input  logic clear,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Shift the raw input through two flops; both clear to 0.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/count_enable_gen.sv
// Button / auto-mode front end for the 4-bit JK counter. Debounces the
// push-button into single-cycle count_enable pulses, fires sync_clear on a
// long press, and in auto mode emits count_enable every PRESCALE cycles.
// Parameters must satisfy DEB_CYCLES, HOLD_CYCLES, PRESCALE >= 2 and < 2**CNT_W.
module count_enable_gen
  import count_enable_gen_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int unsigned PRESCALE    = PRESCALE_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic clock,
  input  logic clear,
  input  logic btn_raw,
  input  logic auto_mode,
  output logic count_enable,
  output logic sync_clear,
  output logic btn_level
);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  btn_state_e       r_state;
  logic [CNT_W-1:0] r_deb_cnt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] r_presc;
  logic             r_count_enable;
  logic             r_sync_clear;
  logic             r_btn_level;

  logic w_btn_s;
  logic w_press_fire;
  logic w_hold_fire;
  logic w_presc_wrap;

  count_enable_gen_sync2 u_sync (
    .clock (clock),
    .clear (clear),
    .d     (btn_raw),
    .q     (w_btn_s)
  );

  // Events resolved this cycle; the counters stop at their terminal values
  // because the FSM leaves the counting state on the same edge.
  assign w_press_fire = (r_state == ST_PRESS_DB) && w_btn_s && (r_deb_cnt == DEB_LAST);
  assign w_hold_fire  = (r_state == ST_PRESSED) && w_btn_s && (r_hold_cnt == HOLD_LAST);
  assign w_presc_wrap = auto_mode && (r_presc == PRESC_LAST);

  // Debounce / hold FSM with its counters and the registered button level.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state     <= ST_IDLE;
      r_deb_cnt   <= '0;
      r_hold_cnt  <= '0;
      r_btn_level <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_btn_s) begin
            r_state   <= ST_PRESS_DB;
            r_deb_cnt <= '0;
          end
        end
        ST_PRESS_DB: begin
          if (!w_btn_s) begin
            r_state <= ST_IDLE;
          end else if (r_deb_cnt == DEB_LAST) begin
            r_state     <= ST_PRESSED;
            r_hold_cnt  <= '0;
            r_btn_level <= 1'b1;
          end else begin
            r_deb_cnt <= r_deb_cnt + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (!w_btn_s) begin
            r_state   <= ST_REL_DB;
            r_deb_cnt <= '0;
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_state <= ST_HELD;
          end else begin
            r_hold_cnt <= r_hold_cnt + CNT_ONE;
          end
        end
        ST_HELD: begin
          if (!w_btn_s) begin
            r_state   <= ST_REL_DB;
            r_deb_cnt <= '0;
          end
        end
        ST_REL_DB: begin
          // A re-press while the release is still bouncing is not a new press.
          if (w_btn_s) begin
            r_state <= ST_HELD;
          end else if (r_deb_cnt == DEB_LAST) begin
            r_state     <= ST_IDLE;
            r_btn_level <= 1'b0;
          end else begin
            r_deb_cnt <= r_deb_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_btn_level <= 1'b0;
        end
      endcase
    end
  end

  // Auto-mode prescaler: idles at 0 outside auto mode, restarts on a clear.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_presc <= '0;
    end else if (!auto_mode || w_hold_fire || w_presc_wrap) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + CNT_ONE;
    end
  end

  // Output pulses; a clear request suppresses a coincident count pulse.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_count_enable <= 1'b0;
      r_sync_clear   <= 1'b0;
    end else begin
      r_sync_clear   <= w_hold_fire;
      r_count_enable <= !w_hold_fire && (auto_mode ? w_presc_wrap : w_press_fire);
    end
  end

  assign count_enable = r_count_enable;
  assign sync_clear   = r_sync_clear;
  assign btn_level    = r_btn_level;

endmodule

// File: tb/tb_count_enable_gen.sv
// Directed bench for count_enable_gen with DEB_CYCLES=4, HOLD_CYCLES=8,
// PRESCALE=5. Edge numbers in expectations count from the first rising
// edge after the stimulus for that sequence is applied.
module tb_count_enable_gen;
  import count_enable_gen_pkg::*;

  logic clock = 1'b0;
  logic clear;
  logic btn_raw;
  logic auto_mode;
  logic count_enable;
  logic sync_clear;
  logic btn_level;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic btn;
    logic auto_m;
    logic ce;
    logic sc;
    logic lvl;
  } vec_t;

  vec_t vecs [18];

  count_enable_gen #(
    .DEB_CYCLES  (4),
    .HOLD_CYCLES (8),
    .PRESCALE    (5),
    .CNT_W       (16)
  ) dut (
    .clock        (clock),
    .clear        (clear),
    .btn_raw      (btn_raw),
    .auto_mode    (auto_mode),
    .count_enable (count_enable),
    .sync_clear   (sync_clear),
    .btn_level    (btn_level)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic b, input logic a);
    btn_raw   = b;
    auto_mode = a;
    tick();
  endtask

  task automatic check3(input string name, input int cyc,
                        input logic e_ce, input logic e_sc, input logic e_lvl);
    n_checks++;
    if ({count_enable, sync_clear, btn_level} !== {e_ce, e_sc, e_lvl}) begin
      n_fail++;
      $display("FAIL %s edge %0d: ce/sc/lvl got %b%b%b expected %b%b%b",
               name, cyc, count_enable, sync_clear, btn_level, e_ce, e_sc, e_lvl);
    end
  endtask

  task automatic check_state(input string name, input btn_state_e exp);
    n_checks++;
    if (dut.r_state !== exp) begin
      n_fail++;
      $display("FAIL %s: state got %0d expected %0d", name, dut.r_state, exp);
    end
  endtask

  task automatic settle();
    btn_raw   = 1'b0;
    auto_mode = 1'b0;
    repeat (12) tick();
    check_state("settle_idle", ST_IDLE);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Clean press: btn high for edges 1..10, pulse after edge 7,
    // release enters REL_DB at edge 13, back to IDLE at edge 17.
    //            btn   auto  ce    sc    lvl
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset held with the button already pressed.
    clear     = 1'b0;
    btn_raw   = 1'b1;
    auto_mode = 1'b0;
    repeat (3) tick();
    check3("reset", 0, 1'b0, 1'b0, 1'b0);
    check_state("reset_state", ST_IDLE);

    // Release reset: pulse only after the full synchroniser + debounce delay.
    clear = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step(1'b1, 1'b0);
      check3("reset_release", e, e == 7, 1'b0, e == 7);
    end

    // Reset while the pulse is high drops it immediately.
    clear = 1'b0;
    #1;
    check3("reset_midop", 0, 1'b0, 1'b0, 1'b0);
    check_state("reset_midop_state", ST_IDLE);
    btn_raw = 1'b0;
    repeat (2) tick();
    clear = 1'b1;
    settle();

    // Table-driven clean press.
    for (int i = 0; i < 18; i++) begin
      step(vecs[i].btn, vecs[i].auto_m);
      check3("clean_press", i + 1, vecs[i].ce, vecs[i].sc, vecs[i].lvl);
    end
    settle();

    // Bounce: high 2, low 1, three times, then steady until edge 20.
    for (int e = 1; e <= 28; e++) begin
      step((e >= 10 && e <= 20) || (e <= 9 && (e % 3) != 0), 1'b0);
      check3("bounce", e, e == 16, 1'b0, e >= 16 && e < 27);
      if (e == 11) check_state("bounce_idle_e11", ST_IDLE);
      if (e == 12) check_state("bounce_pdb_e12", ST_PRESS_DB);
    end
    settle();

    // Long press: 20 cycles held, release reaches IDLE at edge 27.
    for (int e = 1; e <= 30; e++) begin
      step(e <= 20, 1'b0);
      check3("long_press", e, e == 7, e == 15, e >= 7 && e < 27);
      if (e == 16) check_state("long_held", ST_HELD);
    end
    settle();

    // Auto mode alone: pulse every 5th edge.
    for (int e = 1; e <= 22; e++) begin
      step(1'b0, 1'b1);
      check3("auto", e, (e % 5) == 0, 1'b0, 1'b0);
    end
    settle();

    // Auto mode with a short tap: the accepted press adds no pulse.
    for (int e = 1; e <= 22; e++) begin
      step(e <= 6, 1'b1);
      check3("auto_tap", e, (e % 5) == 0, 1'b0, e >= 7 && e < 13);
    end
    settle();

    // Clash: sync_clear lands on the wrap at edge 15 and wins.
    for (int e = 1; e <= 30; e++) begin
      step(e <= 20, 1'b1);
      check3("clash", e, e == 5 || e == 10 || e == 20 || e == 25 || e == 30,
             e == 15, e >= 7 && e < 27);
    end
    settle();

    // sync_clear off the wrap edge still restarts the prescaler.
    for (int e = 1; e <= 32; e++) begin
      step(e >= 3 && e <= 22, 1'b1);
      check3("clear_reload", e,
             e == 5 || e == 10 || e == 15 || e == 22 || e == 27 || e == 32,
             e == 17, e >= 9 && e < 29);
    end
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
